// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one frame per start request, MSB first, four chip-selects.
// sclk, mosi and cs_n come straight from flops so the pins stay glitch-free.
module spi_master_ctrl #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 6
) (
    input  logic              clk,
    input  logic              async_reset,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [1:0]        cs_sel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [3:0]        cs_n
);

    localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
    localparam logic [5:0] LAST_BIT = 6'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_cnt;
    logic [5:0]        r_bits;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] r_rx_data;
    logic [3:0]        r_cs_n;
    logic              r_sclk;
    logic              r_done;
    logic              r_arm;
    logic              r_miso_s1;
    logic              r_miso_s2;
    logic              w_phase_end;
    logic              w_last_bit;
    logic              w_accept;
    logic              w_finish;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) r_state <= IDLE;
        else             r_state <= w_state_nxt;
    end

    // r_arm blocks acceptance on the first edge after reset; r_done blocks it in the done cycle
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_phase_end = (r_cnt == 8'd0);
        w_last_bit  = (r_bits == LAST_BIT);
        case (r_state)
            IDLE: begin
                if (start && r_arm && !r_done) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP:    if (w_phase_end) w_state_nxt = SHIFT_HI;
            SHIFT_HI: if (w_phase_end) w_state_nxt = SHIFT_LO;
            SHIFT_LO: if (w_phase_end) w_state_nxt = w_last_bit ? HOLD : SHIFT_HI;
            HOLD:     if (w_phase_end) w_state_nxt = GAP;
            GAP:      if (w_phase_end) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
        w_finish = (r_state == GAP) && (w_state_nxt == IDLE);
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_cnt     <= '0;
            r_bits    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_cs_n    <= '1;
            r_sclk    <= 1'b0;
            r_done    <= 1'b0;
            r_arm     <= 1'b0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_arm     <= 1'b1;
            r_miso_s1 <= miso;
            r_miso_s2 <= r_miso_s1;
            r_done    <= w_finish;
            r_sclk    <= (w_state_nxt == SHIFT_HI);

            if (w_state_nxt != r_state) r_cnt <= DIV_M1;
            else if (!w_phase_end)      r_cnt <= r_cnt - 8'd1;

            if (w_accept) begin
                r_tx   <= tx_data;
                r_rx   <= '0;
                r_bits <= '0;
                r_cs_n <= ~(4'b0001 << cs_sel);
            end

            // mosi is the shift-register MSB, so it moves only on the sclk falling edge
            if (r_state == SHIFT_HI && w_phase_end) begin
                r_rx <= {r_rx[DATA_W-2:0], r_miso_s2};
                if (!w_last_bit) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end

            if (r_state == SHIFT_LO && w_phase_end) r_bits <= r_bits + 6'd1;

            if (r_state == HOLD && w_phase_end) begin
                r_cs_n <= '1;
                r_tx   <= '0;
            end

            if (w_finish) r_rx_data <= r_rx;
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign mosi    = r_tx[DATA_W-1];
    assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboarded bench for spi_master_ctrl: a default-parameter instance with a slave model
// and an 8-bit/CLK_DIV=3 instance in MISO=MOSI loopback.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        start_a = 1'b0;
    logic [15:0] tx_a    = '0;
    logic [1:0]  sel_a   = '0;
    logic        miso_a  = 1'b0;
    logic        busy_a, done_a, sclk_a, mosi_a;
    logic [15:0] rx_a;
    logic [3:0]  cs_n_a;

    logic        start_b = 1'b0;
    logic [7:0]  tx_b    = '0;
    logic [1:0]  sel_b   = '0;
    logic        miso_b;
    logic        busy_b, done_b, sclk_b, mosi_b;
    logic [7:0]  rx_b;
    logic [3:0]  cs_n_b;

    assign miso_b = mosi_b;

    spi_master_ctrl u_dut_a (
        .clk(clk), .async_reset(rst), .start(start_a), .tx_data(tx_a), .cs_sel(sel_a),
        .busy(busy_a), .done(done_a), .rx_data(rx_a), .sclk(sclk_a), .mosi(mosi_a),
        .miso(miso_a), .cs_n(cs_n_a)
    );

    spi_master_ctrl #(.DATA_W(8), .CLK_DIV(3)) u_dut_b (
        .clk(clk), .async_reset(rst), .start(start_b), .tx_data(tx_b), .cs_sel(sel_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b), .sclk(sclk_b), .mosi(mosi_b),
        .miso(miso_b), .cs_n(cs_n_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rx;
        int          t;
        logic [31:0] stx;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    // Slave for instance A: loads slv_val on CS fall, shifts MISO on sclk fall, captures MOSI on sclk rise
    logic [15:0] slv_val = '0;
    logic [15:0] slv_sh  = '0;
    logic [15:0] slv_rx  = '0;
    logic        cs_prev = 1'b1;
    logic        cs_hi_a;
    assign cs_hi_a = &cs_n_a;

    always @(posedge sclk_a) slv_rx = {slv_rx[14:0], mosi_a};

    always @(negedge sclk_a or negedge cs_hi_a or posedge cs_hi_a) begin
        if (!cs_hi_a && cs_prev) slv_sh = slv_val;
        else if (!cs_hi_a)       slv_sh = slv_sh << 1;
        miso_a  = slv_sh[15];
        cs_prev = cs_hi_a;
    end

    int   viol_cs = 0, viol_mosi = 0, viol_sclk = 0;
    int   rise_a = 0, gap_run_b = 0, last_gap_b = 0;
    logic prev_sclk_a = 1'b0, prev_mosi_a = 1'b0, prev_sclk_b = 1'b0, prev_mosi_b = 1'b0;
    exp_t ea, eb;

    always @(negedge clk) begin
        if (done_a) begin
            if (q_a.size() == 0) chk("a_spurious_done", 32'(done_a), 32'd0);
            else begin
                ea = q_a.pop_front();
                chk("a_rx_data", 32'(rx_a), ea.rx);
                chk("a_done_time", cyc, ea.t);
                chk("a_busy_at_done", 32'(busy_a), 32'd0);
                chk("a_slave_got_mosi", 32'(slv_rx), ea.stx);
            end
        end
        if (done_b) begin
            if (q_b.size() == 0) chk("b_spurious_done", 32'(done_b), 32'd0);
            else begin
                eb = q_b.pop_front();
                chk("b_rx_loopback", 32'(rx_b), eb.rx);
                chk("b_done_time", cyc, eb.t);
                chk("b_busy_at_done", 32'(busy_b), 32'd0);
            end
        end
        if ($countones(~cs_n_a) > 1 || $countones(~cs_n_b) > 1) viol_cs++;
        if ((sclk_a && prev_sclk_a && mosi_a != prev_mosi_a) ||
            (sclk_b && prev_sclk_b && mosi_b != prev_mosi_b)) viol_mosi++;
        if ((sclk_a && cs_hi_a) || (sclk_b && &cs_n_b)) viol_sclk++;
        if (sclk_a && !prev_sclk_a) rise_a++;
        if (&cs_n_b) gap_run_b++;
        else begin
            if (gap_run_b > 0) last_gap_b = gap_run_b;
            gap_run_b = 0;
        end
        prev_sclk_a = sclk_a; prev_mosi_a = mosi_a;
        prev_sclk_b = sclk_b; prev_mosi_b = mosi_b;
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called on a negedge; start is sampled at the following posedge, which closes cycle T0
    task automatic xfer_a(input logic [15:0] d, input logic [1:0] s, input logic [15:0] srx,
                          input bit push, output int t0);
        start_a = 1'b1; tx_a = d; sel_a = s; slv_val = srx; t0 = cyc;
        if (push) q_a.push_back('{rx: 32'(srx), t: cyc + 211, stx: 32'(d)});
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic xfer_b(input logic [7:0] d, input logic [1:0] s, output int t0);
        start_b = 1'b1; tx_b = d; sel_b = s; t0 = cyc;
        q_b.push_back('{rx: 32'(d), t: cyc + 58, stx: 32'd0});
        @(negedge clk);
        start_b = 1'b0;
    endtask

    int t0, t1, base;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(sclk_a), 32'd0);
        chk("rst_mosi", 32'(mosi_a), 32'd0);
        chk("rst_cs_n", 32'(cs_n_a), 32'hF);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_rx", 32'(rx_a), 32'd0);
        chk("rst_cs_n_b", 32'(cs_n_b), 32'hF);

        rst = 1'b0; start_a = 1'b1; tx_a = 16'hFFFF; sel_a = 2'd3;
        @(negedge clk);
        start_a = 1'b0;
        chk("first_edge_start_ignored", 32'(busy_a), 32'd0);
        repeat (2) @(negedge clk);

        base = rise_a;
        xfer_a(16'hA55A, 2'd2, 16'h3C96, 1'b1, t0);
        chk("a_busy_t1", 32'(busy_a), 32'd1);
        chk("a_cs_n_sel2", 32'(cs_n_a), 32'hB);
        chk("a_mosi_msb_t1", 32'(mosi_a), 32'd1);
        wait_until(t0 + 6);
        chk("a_sclk_low_setup_end", 32'(sclk_a), 32'd0);
        wait_until(t0 + 7);
        chk("a_sclk_first_rise", 32'(sclk_a), 32'd1);
        wait_until(t0 + 212);
        chk("a_sclk_rises", rise_a - base, 32'd16);
        chk("a_rx_stable", 32'(rx_a), 32'h3C96);
        chk("a_cs_released", 32'(cs_n_a), 32'hF);

        xfer_a(16'h1234, 2'd1, 16'h0F0F, 1'b1, t0);
        wait_until(t0 + 50);
        start_a = 1'b1; tx_a = 16'hFFFF; sel_a = 2'd3;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_cs_n_after_mid_start", 32'(cs_n_a), 32'hD);
        wait_until(t0 + 211);
        start_a = 1'b1; tx_a = 16'hBEEF; sel_a = 2'd3;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_start_at_done_ignored", 32'(busy_a), 32'd0);
        chk("a_cs_idle_after_done", 32'(cs_n_a), 32'hF);
        repeat (20) @(negedge clk);
        chk("a_rx_hold", 32'(rx_a), 32'h0F0F);

        xfer_a(16'hFFFF, 2'd3, 16'hAAAA, 1'b0, t0);
        wait_until(t0 + 100);
        chk("a_cs_before_abort", 32'(cs_n_a), 32'h7);
        rst = 1'b1;
        #1;
        chk("abort_cs_n", 32'(cs_n_a), 32'hF);
        chk("abort_sclk", 32'(sclk_a), 32'd0);
        chk("abort_busy", 32'(busy_a), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        xfer_a(16'hC3C3, 2'd0, 16'h5AA5, 1'b1, t0);
        chk("a_cs_n_sel0", 32'(cs_n_a), 32'hE);
        wait_until(t0 + 212);

        xfer_b(8'hB7, 2'd1, t0);
        chk("b_cs_n_sel1", 32'(cs_n_b), 32'hD);
        wait_until(t0 + 59);
        xfer_b(8'h4C, 2'd3, t1);
        chk("b_cs_n_sel3", 32'(cs_n_b), 32'h7);
        @(negedge clk);
        chk("b_gap_ge3", 32'(last_gap_b >= 3), 32'd1);
        wait_until(t1 + 62);

        chk("a_queue_drained", q_a.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);
        chk("onehot_cs_violations", viol_cs, 32'd0);
        chk("mosi_stable_violations", viol_mosi, 32'd0);
        chk("sclk_without_cs_violations", viol_sclk, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 The parameter DATA_W SHALL default to 16 and sets the frame length in bits; legal values are 8 to 32.
REQ-002 The parameter CLK_DIV SHALL default to 6 and sets the SCLK half-period in clk cycles (12 MHz / 12 = 1 MHz SCLK); legal values are 3 to 255.
REQ-003 The port clk SHALL be an input, 1 bit wide: the system clock, 12 MHz nominal; all logic is on its rising edge.
REQ-004 The port async_reset SHALL be an input, 1 bit wide: reset, asynchronous, active-high.
REQ-005 The port start SHALL be an input, 1 bit wide: single-cycle transfer request.
REQ-006 The port tx_data SHALL be an input, DATA_W bits wide: the frame to transmit, MSB first.
REQ-007 The port cs_sel SHALL be an input, 2 bits wide: an index selecting one of 4 peripheral chip-selects.
REQ-008 The port busy SHALL be an output, 1 bit wide: high while a transfer is in progress.
REQ-009 The port done SHALL be an output, 1 bit wide: a one-cycle pulse that marks the end of a transfer.
REQ-010 The port rx_data SHALL be an output, DATA_W bits wide: the frame captured from MISO, MSB first.
REQ-011 The port sclk SHALL be an output, 1 bit wide: the SPI clock, mode 0 (idle low).
REQ-012 The port mosi SHALL be an output, 1 bit wide: serial data out.
REQ-013 The port miso SHALL be an input, 1 bit wide: serial data in, asynchronous to clk.
REQ-014 The port cs_n SHALL be an output, 4 bits wide: active-low chip-selects; at most one bit is low at any time.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP.
REQ-016 In IDLE, start=1 SHALL be accepted in cycle T0: tx_data is latched into the shift register, cs_sel is latched, and the FSM goes to SETUP at T0+1.
REQ-017 start SHALL be ignored in every state other than IDLE, with no queuing and no effect on the transfer in progress.
REQ-018 busy SHALL be high from T0+1 up to and including the cycle before done, and low in the cycle done is high.
REQ-019 In SETUP, cs_n[cs_sel] SHALL be low and mosi SHALL equal tx_data[DATA_W-1] from T0+1; sclk stays low for CLK_DIV cycles.
REQ-020 In SHIFT_HI, sclk SHALL be high for CLK_DIV cycles; in SHIFT_LO, sclk SHALL be low for CLK_DIV cycles.
REQ-021 mosi SHALL change only on the cycle sclk falls, shifting to the next lower bit, and SHALL hold after the last bit until the FSM leaves HOLD.
REQ-022 miso SHALL pass through a 2-flop synchroniser and SHALL be sampled into the receive register in the last cycle of each SHIFT_HI period (valid because CLK_DIV is at least 3).
REQ-023 A 6-bit bit counter SHALL count DATA_W SHIFT_HI/SHIFT_LO pairs; after the DATA_W-th SHIFT_LO the FSM goes to HOLD.
REQ-024 HOLD SHALL keep sclk low and CS asserted for CLK_DIV cycles; CS is then deasserted (all cs_n=1) on entry to GAP.
REQ-025 GAP SHALL last CLK_DIV cycles with all cs_n=1; the FSM then goes to IDLE.
REQ-026 On the IDLE-entry cycle, done SHALL be 1 and rx_data SHALL be updated with the received frame in the same cycle; rx_data is otherwise stable.
REQ-027 Total latency SHALL be: done high exactly at T0 + CLK_DIV*(2*DATA_W+3) + 1.
REQ-028 start asserted in the same cycle as done SHALL be ignored; the earliest accept is the cycle after done.
REQ-029 sclk, mosi and cs_n SHALL be registered outputs, free of glitches.
REQ-030 A half-period counter SHALL be 8 bits wide and reload to CLK_DIV-1 at every phase change.

Reset
REQ-031 While async_reset=1, outputs SHALL be forced immediately, regardless of clk: sclk=0, mosi=0, cs_n=4'b1111, busy=0, done=0, rx_data=0, FSM=IDLE, with all counters and shift and synchroniser registers cleared.
REQ-032 Reset mid-transfer SHALL abort the transfer without producing a done pulse; cs_n deasserts asynchronously.
REQ-033 After reset release, the first start SHALL be accepted no earlier than the second rising edge of clk.

Verification
REQ-034 Default parameters, start with tx_data=16'hA55A and cs_sel=2 -> cs_n=4'b1011 during the transfer, mosi carries A55A MSB first, 16 sclk rising edges at 1 MHz, done at T0+211.
REQ-035 MISO loopback from a slave model returning 16'h3C96 -> rx_data=16'h3C96 when done pulses, unchanged afterwards.
REQ-036 start pulsed at T0+50 and at the done cycle with different data -> both requests ignored, and mosi/rx_data are unaffected.
REQ-037 async_reset asserted at T0+100 -> cs_n=4'b1111 and sclk=0 within the same cycle, no done pulse; after release, a new transfer with cs_sel=0 completes normally.
REQ-038 DATA_W=8, CLK_DIV=3, back-to-back starts on cs_sel=1 then 3 -> each done at T0+58, GAP of at least 3 cycles with all cs_n high between frames.
REQ-039 Assertion bench: at most one cs_n bit is low in every cycle, mosi is stable while sclk is high, and sclk is low whenever all cs_n are 1.
